mti_canceller: RTL

MTI_CANCELLER -- requirements
Module: mti_canceller

---
 rtl/mti_canceller.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mti_canceller.sv
// rtl/mti_canceller.sv - two-pulse MTI clutter canceller (current minus previous PRI)
//
// Subtracts each range bin of the previous pulse from the same bin of the
// current pulse, cancelling stationary clutter. The first pulse of every CPI
// only fills the delay buffer.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   pulse_start  one-cycle PRI start marker
//   in_valid     input sample valid
//   in_I, in_Q   signed WIDTH-bit input sample
//   out_valid    cancelled sample valid (2 cycles after accepted input)
//   out_I, out_Q signed WIDTH+1-bit difference, held while out_valid=0
//   range_idx    range bin of the output sample
//   pulse_idx    pulse number of the output sample within the CPI
//   cpi_done     one-cycle flag with the last output of the CPI
module mti_canceller #(
  parameter int WIDTH   = 36,
  parameter int N_RANGE = 1000,
  parameter int PRF_N   = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pulse_start,
  input  logic                         in_valid,
  input  logic signed [WIDTH-1:0]      in_I,
  input  logic signed [WIDTH-1:0]      in_Q,
  output logic                         out_valid,
  output logic signed [WIDTH:0]        out_I,
  output logic signed [WIDTH:0]        out_Q,
  output logic [$clog2(N_RANGE)-1:0]   range_idx,
  output logic [$clog2(PRF_N)-1:0]     pulse_idx,
  output logic                         cpi_done
);

  localparam int AW = $clog2(N_RANGE);
  localparam int PW = $clog2(PRF_N);
  // One extra state of headroom so the range counter can park at N_RANGE.
  localparam int RW = $clog2(N_RANGE + 1);

  typedef enum logic [1:0] {IDLE, FILL, CANCEL} state_t;

  state_t        state, eff_state;
  logic [PW-1:0] pcnt, eff_pcnt;
  logic [RW-1:0] rcnt, eff_rcnt;
  logic          accept;
  logic [AW-1:0] addr;

  // eff_* is the context that applies to the sample in this cycle: a
  // pulse_start arriving with in_valid makes that sample bin 0 of the new
  // pulse, so the transition is resolved combinationally before acceptance.
  always_comb begin
    eff_state = state;
    eff_pcnt  = pcnt;
    eff_rcnt  = rcnt;
    if (pulse_start) begin
      eff_rcnt = '0;
      case (state)
        IDLE: begin
          eff_state = FILL;
          eff_pcnt  = '0;
        end
        FILL: begin
          eff_state = CANCEL;
          eff_pcnt  = PW'(1);
        end
        CANCEL: begin
          if (pcnt == PW'(PRF_N - 1)) begin
            eff_state = FILL;
            eff_pcnt  = '0;
          end else begin
            eff_state = CANCEL;
            eff_pcnt  = pcnt + PW'(1);
          end
        end
        default: begin
          eff_state = IDLE;
          eff_pcnt  = '0;
        end
      endcase
    end
    accept = in_valid && (eff_state != IDLE) && (eff_rcnt < RW'(N_RANGE));
    addr   = eff_rcnt[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcnt  <= '0;
      rcnt  <= '0;
    end else begin
      state <= eff_state;
      pcnt  <= eff_pcnt;
      // Saturates at N_RANGE because overrun samples are not accepted.
      rcnt  <= accept ? eff_rcnt + RW'(1) : eff_rcnt;
    end
  end

  // Delay line: one I/Q entry per range bin. Read and write share the
  // address on the same edge, so the read returns the previous pulse.
  logic signed [WIDTH-1:0] mem_i [N_RANGE];
  logic signed [WIDTH-1:0] mem_q [N_RANGE];
  logic signed [WIDTH-1:0] prev_i, prev_q;

  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      prev_i      <= mem_i[addr];
      prev_q      <= mem_q[addr];
      mem_i[addr] <= in_I;
      mem_q[addr] <= in_Q;
    end
  end

  // Stage 1: current sample and its tags, aligned with the buffer read.
  logic                    s1_valid;
  logic                    s1_last;
  logic signed [WIDTH-1:0] s1_cur_i, s1_cur_q;
  logic [AW-1:0]           s1_range;
  logic [PW-1:0]           s1_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_cur_i <= '0;
      s1_cur_q <= '0;
      s1_range <= '0;
      s1_pulse <= '0;
    end else begin
      s1_valid <= accept && (eff_state == CANCEL);
      if (accept) begin
        s1_cur_i <= in_I;
        s1_cur_q <= in_Q;
        s1_range <= addr;
        s1_pulse <= eff_pcnt;
        s1_last  <= (eff_rcnt == RW'(N_RANGE - 1)) && (eff_pcnt == PW'(PRF_N - 1));
      end
    end
  end

  // Sign-extend before subtracting so the full-scale swing fits in WIDTH+1.
  logic signed [WIDTH:0] diff_i, diff_q;
  assign diff_i = {s1_cur_i[WIDTH-1], s1_cur_i} - {prev_i[WIDTH-1], prev_i};
  assign diff_q = {s1_cur_q[WIDTH-1], s1_cur_q} - {prev_q[WIDTH-1], prev_q};

  // Stage 2: registered outputs; data and tags hold between valid samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      cpi_done  <= 1'b0;
      out_I     <= '0;
      out_Q     <= '0;
      range_idx <= '0;
      pulse_idx <= '0;
    end else begin
      out_valid <= s1_valid;
      cpi_done  <= s1_valid && s1_last;
      if (s1_valid) begin
        out_I     <= diff_i;
        out_Q     <= diff_q;
        range_idx <= s1_range;
        pulse_idx <= s1_pulse;
      end
    end
  end

endmodule
